// File: rtl/sdr_rx_ctrl.sv
// Receive sequencer for the 8-bit SDR capture path: training lock, frame delimiting
// (SOF, length, payload) and a first-word-fall-through payload FIFO.
module sdr_rx_ctrl #(
  parameter logic [7:0]  TRAIN_PAT = 8'hA5,
  parameter int unsigned TRAIN_CNT = 8,
  parameter logic [7:0]  SOF       = 8'h7E,
  parameter int unsigned DEPTH     = 16
) (
  input  logic       sclk,
  input  logic       reset,
  input  logic       rx_en,
  input  logic [7:0] q,
  output logic       cap_en,
  output logic       locked,
  output logic [7:0] dout,
  output logic       dout_valid,
  output logic       dout_last,
  input  logic       dout_ready,
  output logic       err,
  output logic       ovf
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [AW:0] FullCnt = (AW+1)'(DEPTH);
  localparam logic [7:0]  LockCnt = 8'(TRAIN_CNT - 1);

  typedef enum logic [2:0] {StIdle, StTrain, StHunt, StLen, StPayload} state_e;

  state_e     r_state;
  logic [7:0] r_cnt;
  logic [7:0] r_rem;
  logic       r_cap_en;
  logic       r_locked;
  logic       r_err;

  logic [8:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_count;
  logic          r_ovf;

  logic       w_push;
  logic       w_push_last;
  logic       w_empty;
  logic       w_full;
  logic       w_pop;
  logic       w_wr;
  logic [8:0] w_head;

  // Dropping rx_en abandons the frame immediately, so that cycle's byte is not pushed.
  assign w_push      = (r_state == StPayload) && rx_en;
  assign w_push_last = (r_rem == 8'd1);
  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == FullCnt);
  assign w_pop       = !w_empty && dout_ready;
  assign w_wr        = w_push && (!w_full || w_pop);
  assign w_head      = r_mem[r_rd];

  always_ff @(posedge sclk) begin
    if (reset) begin
      r_state  <= StIdle;
      r_cnt    <= 8'd0;
      r_rem    <= 8'd0;
      r_cap_en <= 1'b0;
      r_locked <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (r_state != StIdle && !rx_en) begin
        r_state  <= StIdle;
        r_locked <= 1'b0;
        r_cap_en <= 1'b0;
      end else begin
        case (r_state)
          StIdle: begin
            if (rx_en) begin
              r_state  <= StTrain;
              r_cnt    <= 8'd0;
              r_cap_en <= 1'b1;
            end
          end
          StTrain: begin
            if (q == TRAIN_PAT) begin
              if (r_cnt == LockCnt) begin
                r_state  <= StHunt;
                r_locked <= 1'b1;
                r_cnt    <= 8'd0;
              end else begin
                r_cnt <= r_cnt + 8'd1;
              end
            end else begin
              r_cnt <= 8'd0;
            end
          end
          StHunt: begin
            if (q == SOF) begin
              r_state <= StLen;
            end else if (q != TRAIN_PAT) begin
              r_state  <= StTrain;
              r_locked <= 1'b0;
              r_err    <= 1'b1;
              r_cnt    <= 8'd0;
            end
          end
          StLen: begin
            r_rem <= q;
            if (q == 8'd0) begin
              r_state <= StHunt;
              r_err   <= 1'b1;
            end else begin
              r_state <= StPayload;
            end
          end
          StPayload: begin
            r_rem <= r_rem - 8'd1;
            if (r_rem == 8'd1) r_state <= StHunt;
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  // Storage is not reset; the pointers and count define what is valid.
  always_ff @(posedge sclk) begin
    if (w_wr) r_mem[r_wr] <= {w_push_last, q};
  end

  always_ff @(posedge sclk) begin
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_wr)  r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_push && !w_wr) r_ovf <= 1'b1;
    end
  end

  assign cap_en     = r_cap_en;
  assign locked     = r_locked;
  assign err        = r_err;
  assign ovf        = r_ovf;
  assign dout_valid = !w_empty;
  assign dout       = w_empty ? 8'h00 : w_head[7:0];
  assign dout_last  = !w_empty && w_head[8];

endmodule

// File: tb/tb_sdr_rx_ctrl.sv
// Bench for sdr_rx_ctrl: cycle vector table for lock/frame sequencing, payload scoreboard,
// and hand-written overflow, reset and disable sequences.
module tb_sdr_rx_ctrl;

  logic       sclk = 1'b0;
  logic       reset;
  logic       rx_en;
  logic [7:0] q;
  logic       cap_en;
  logic       locked;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_last;
  logic       dout_ready;
  logic       err;
  logic       ovf;

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] sb[$];

  typedef struct {
    logic       en;
    logic [7:0] d;
    logic       pay;
    logic       last;
    logic       cap;
    logic       lck;
    logic       er;
  } vec_t;

  vec_t vecs[$];

  sdr_rx_ctrl #(
    .TRAIN_PAT (8'hA5),
    .TRAIN_CNT (8),
    .SOF       (8'h7E),
    .DEPTH     (16)
  ) dut (
    .sclk       (sclk),
    .reset      (reset),
    .rx_en      (rx_en),
    .q          (q),
    .cap_en     (cap_en),
    .locked     (locked),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_last  (dout_last),
    .dout_ready (dout_ready),
    .err        (err),
    .ovf        (ovf)
  );

  always #5 sclk = ~sclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock; pops seen before the edge are compared against the scoreboard after it.
  task automatic tick();
    logic       pv;
    logic [8:0] pa;
    pv = dout_valid && dout_ready && !reset;
    pa = {dout_last, dout};
    @(posedge sclk);
    #1;
    if (reset) begin
      sb.delete();
    end else if (pv) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pop: got %0h expected none", pa);
      end else begin
        chk("pop_data", 32'(pa), 32'(sb.pop_front()));
      end
    end
  endtask

  function automatic void add(input logic en, input logic [7:0] d, input logic pay,
                              input logic last, input logic cap, input logic lck,
                              input logic er);
    vec_t v;
    v.en = en; v.d = d; v.pay = pay; v.last = last; v.cap = cap; v.lck = lck; v.er = er;
    vecs.push_back(v);
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cap_en"}, 32'(cap_en), 0);
    chk({tag, "_locked"}, 32'(locked), 0);
    chk({tag, "_dout"}, 32'(dout), 0);
    chk({tag, "_dout_valid"}, 32'(dout_valid), 0);
    chk({tag, "_dout_last"}, 32'(dout_last), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_ovf"}, 32'(ovf), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic lock();
    rx_en = 1'b1;
    q     = 8'h00;
    tick();
    for (int i = 0; i < 8; i++) begin
      q = 8'hA5;
      tick();
    end
    chk("relock", 32'(locked), 1);
  endtask

  task automatic drain(input string tag);
    dout_ready = 1'b1;
    for (int i = 0; i < 64 && sb.size() != 0; i++) tick();
    tick();
    chk({tag, "_sb_empty"}, 32'(sb.size()), 0);
    chk({tag, "_fifo_empty"}, 32'(dout_valid), 0);
  endtask

  initial begin
    reset      = 1'b1;
    rx_en      = 1'b0;
    q          = 8'h00;
    dout_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check_reset_outputs("rst");

    // en, q, payload, last, exp cap_en, exp locked, exp err
    add(1, 8'h00, 0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) add(1, 8'hA5, 0, 0, 1, 0, 0);
    add(1, 8'h3C, 0, 0, 1, 0, 0);
    for (int i = 0; i < 7; i++) add(1, 8'hA5, 0, 0, 1, 0, 0);
    add(1, 8'hA5, 0, 0, 1, 1, 0);
    add(1, 8'hA5, 0, 0, 1, 1, 0);
    add(1, 8'h7E, 0, 0, 1, 1, 0);
    add(1, 8'h03, 0, 0, 1, 1, 0);
    add(1, 8'h11, 1, 0, 1, 1, 0);
    add(1, 8'h22, 1, 0, 1, 1, 0);
    add(1, 8'h33, 1, 1, 1, 1, 0);
    add(1, 8'h7E, 0, 0, 1, 1, 0);
    add(1, 8'h00, 0, 0, 1, 1, 1);
    add(1, 8'h7E, 0, 0, 1, 1, 0);
    add(1, 8'h01, 0, 0, 1, 1, 0);
    add(1, 8'h55, 1, 1, 1, 1, 0);
    add(1, 8'h5C, 0, 0, 1, 0, 1);
    for (int i = 0; i < 7; i++) add(1, 8'hA5, 0, 0, 1, 0, 0);
    add(1, 8'hA5, 0, 0, 1, 1, 0);
    add(1, 8'hA5, 0, 0, 1, 1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      rx_en = vecs[i].en;
      q     = vecs[i].d;
      if (vecs[i].pay) sb.push_back({vecs[i].last, vecs[i].d});
      tick();
      chk($sformatf("vec%0d_cap_en", i), 32'(cap_en), 32'(vecs[i].cap));
      chk($sformatf("vec%0d_locked", i), 32'(locked), 32'(vecs[i].lck));
      chk($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].er));
    end
    drain("frames");

    // Overflow: 20-byte frame into a 16-entry FIFO with the consumer stalled.
    dout_ready = 1'b0;
    q = 8'h7E; tick();
    q = 8'h14; tick();
    for (int i = 1; i <= 20; i++) begin
      q = 8'(8'h80 + i);
      if (i <= 16) sb.push_back({1'b0, q});
      tick();
      chk($sformatf("ovf_after_byte%0d", i), 32'(ovf), (i >= 17) ? 1 : 0);
    end
    q = 8'hA5; tick(); tick();
    chk("full_head_held", 32'(dout), 32'h81);
    chk("full_valid", 32'(dout_valid), 1);

    // Push and pop together while full: nothing dropped.
    q = 8'h7E; tick();
    q = 8'h02; tick();
    dout_ready = 1'b1;
    q = 8'hC1; sb.push_back({1'b0, q}); tick();
    q = 8'hC2; sb.push_back({1'b1, q}); tick();
    q = 8'hA5;
    drain("ovf");
    chk("ovf_sticky", 32'(ovf), 1);

    // Reset mid-payload flushes everything, including sticky ovf.
    do_reset();
    check_reset_outputs("rst2");
    lock();
    dout_ready = 1'b0;
    q = 8'h7E; tick();
    q = 8'h05; tick();
    q = 8'hD1; tick();
    q = 8'hD2; tick();
    chk("pre_reset_valid", 32'(dout_valid), 1);
    reset = 1'b1;
    q     = 8'hD3;
    tick();
    reset = 1'b0;
    check_reset_outputs("midrst");

    // rx_en dropped mid-payload: bytes already pushed still drain, no err.
    lock();
    q = 8'h7E; tick();
    q = 8'h05; tick();
    q = 8'hE1; sb.push_back({1'b0, q}); tick();
    q = 8'hE2; sb.push_back({1'b0, q}); tick();
    rx_en = 1'b0;
    q     = 8'hE3;
    tick();
    chk("dis_cap_en", 32'(cap_en), 0);
    chk("dis_locked", 32'(locked), 0);
    chk("dis_err", 32'(err), 0);
    chk("dis_valid", 32'(dout_valid), 1);
    drain("dis");
    chk("dis_err_after", 32'(err), 0);
    chk("dis_cap_after", 32'(cap_en), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sdr_rx_ctrl.md
# sdr_rx_ctrl

Receive-side sequencer for the 8-bit SDR input capture path. Gates the capture enable of the input registers and acquires lock on a training pattern. Delimits frames (SOF, length, payload) from the captured byte stream and buffers payload bytes in a small first-word-fall-through FIFO with a valid/ready output. Sits directly downstream of the SDR input registers, in the `sclk` domain.

## Interface
Parameters:
- `TRAIN_PAT`, 8'hA5, training/idle filler byte
- `TRAIN_CNT`, 8, consecutive `TRAIN_PAT` bytes required for lock (1..255)
- `SOF`, 8'h7E, start-of-frame byte
- `DEPTH`, 16, payload FIFO depth (power of 2, ≥2)

Ports:
- `sclk`  in  1  capture clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `rx_en`  in  1  controller enable
- `q`  in  8  byte captured by the SDR input registers, one per `sclk`
- `cap_en`  out  1  capture enable to input-register SP pins
- `locked`  out  1  training lock achieved
- `dout`  out  8  payload byte at FIFO head
- `dout_valid`  out  1  FIFO not empty
- `dout_last`  out  1  head byte is last of its frame
- `dout_ready`  in  1  consumer accepts head byte when `dout_valid` is high
- `err`  out  1  one-cycle pulse: zero length or loss of lock
- `ovf`  out  1  sticky: payload byte dropped, FIFO full

## Operation
- Reset state: IDLE, FIFO empty. All outputs are 0: `cap_en`, `locked`, `dout`, `dout_valid`, `dout_last`, `err`, `ovf`.
- Registered FSM states: IDLE, TRAIN, HUNT, LEN, PAYLOAD.
- `cap_en` is 1 in every state except IDLE.
- **IDLE**
  - `rx_en`=1 → TRAIN; train counter cleared.
- **TRAIN**
  - `q`==`TRAIN_PAT` increments the counter; any other byte clears it to 0.
  - On the cycle the `TRAIN_PAT` byte bringing the count to `TRAIN_CNT` is sampled → HUNT, and `locked` goes 1.
- **HUNT**
  - `q`==`SOF` → LEN.
  - `q`==`TRAIN_PAT` → stay (filler).
  - Any other byte → TRAIN, `locked`=0, `err` pulse, counter cleared.
- **LEN**
  - `q` is latched as the 8-bit remaining count.
  - `q`==0 → HUNT, `err` pulse, no FIFO write.
  - Otherwise → PAYLOAD.
- **PAYLOAD**
  - Each cycle, `q` is pushed with last flag = (remaining==1), and remaining decrements.
  - At remaining==1 → HUNT.
  - Payload bytes are not interpreted; `SOF`/`TRAIN_PAT` values in the payload are data.
- **`rx_en`=0** in any non-IDLE state:
  - → IDLE next cycle; `locked` cleared.
  - A frame in progress is abandoned; bytes already pushed stay in the FIFO. No `err`.
  - FIFO continues to drain.
- **FIFO** is `DEPTH` entries × 9 bits (byte + last flag), with a log2(`DEPTH`)+1-bit occupancy count.
  - Push accepted if not full, or if full and a pop occurs in the same cycle.
  - Otherwise the byte is dropped and `ovf` is set. `ovf` is cleared only by `reset`.
  - A dropped last byte loses the frame boundary. Consumer must treat `ovf` as fatal.
  - Pop = `dout_valid` & `dout_ready`. `dout_ready` while empty has no effect.
  - Push and pop on the same cycle while empty: push is stored; nothing is popped.
  - Read/write pointers wrap modulo `DEPTH`.
- **`reset`** mid-frame: FSM → IDLE, FIFO flushed, all outputs to reset values on the next edge, regardless of `rx_en`.

## Timing
- `cap_en` goes 1 on the edge after `rx_en` is sampled high in IDLE. The first byte evaluated in TRAIN is the one sampled on the following cycle.
- `locked` is registered: high from the edge that samples the `TRAIN_CNT`-th consecutive pattern byte.
- FIFO-write latency: payload byte on `q` at edge n is written at edge n. If the FIFO was empty, it appears on `dout` with `dout_valid`=1 after edge n (usable in cycle n+1).
- `dout`/`dout_last` are held stable while `dout_valid`=1 and `dout_ready`=0.
- Throughput: one push and one pop per cycle sustained; no bubbles.
- `err` is high for exactly the one cycle following the offending sample.
- Frame overhead: 2 cycles (SOF, LEN) per frame. Back-to-back frames allowed; HUNT accepts `SOF` immediately after the last payload byte.

## Test plan
- Reset, `rx_en`=1, 8×A5 on `q` → `locked`=1 after 8th byte; `cap_en`=1 from cycle after `rx_en`. A mismatch after 5×A5 followed by 8×A5 → lock only after the second run.
- Locked; `q`=7E,03,11,22,33, `dout_ready`=1 → `dout` 11,22,33 on consecutive cycles, `dout_last` only with 33, `err`=0.
- Locked; `q`=7E,00 → single-cycle `err`, no FIFO write, FSM in HUNT (next 7E,01,55 delivers 55 with last).
- Locked; `q`=5C in HUNT → `err` pulse, `locked`=0; 8×A5 relocks.
- `dout_ready`=0; frame of 20 bytes → 16 stored, `ovf`=1 and stays 1. Then release `dout_ready` → 16 bytes 1st..16th drain in order. Also: push+pop same cycle when full → no drop.
- Mid-payload `reset` → all outputs 0 next cycle, FIFO empty; mid-payload `rx_en`=0 → IDLE, prior bytes still drain, no `err`.
